data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/load_store_align.sv | 72 +++++++
 rtl/data_memory.sv | 128 ++++++++++++
 tb/tb_data_memory.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory stage:
// FSM state encoding and RV32 load/store width codes.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for loads and stores: write enables,
// store lane replication, load extension, alignment checks.
module load_store_align
    import data_memory_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] write_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Addressed byte/half lands in the low bits; a misaligned
    // or unknown access gets no byte enables and a zero result.
    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
        misaligned  = 1'b0;
        shifted     = read_word >> {addr_lo, 3'b000};
        if (is_store) begin
            case (func3)
                SB: begin
                    byte_en     = 4'b0001 << addr_lo;
                    store_lanes = {4{write_data[7:0]}};
                end
                SH: begin
                    if (addr_lo[0]) begin
                        misaligned = 1'b1;
                    end else begin
                        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                        store_lanes = {2{write_data[15:0]}};
                    end
                end
                SW: begin
                    if (addr_lo != 2'b00) begin
                        misaligned = 1'b1;
                    end else begin
                        byte_en     = 4'b1111;
                        store_lanes = write_data;
                    end
                end
                default: misaligned = 1'b1;
            endcase
        end else begin
            case (func3)
                LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                LBU: load_data = {24'h0, shifted[7:0]};
                LH: begin
                    if (addr_lo[0]) misaligned = 1'b1;
                    else load_data = {{16{shifted[15]}}, shifted[15:0]};
                end
                LHU: begin
                    if (addr_lo[0]) misaligned = 1'b1;
                    else load_data = {16'h0, shifted[15:0]};
                end
                LW: begin
                    if (addr_lo != 2'b00) misaligned = 1'b1;
                    else load_data = shifted;
                end
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory: latches a request, stalls the
// pipeline for ACCESS_CYCLES+1 cycles, then presents the result.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int DEPTH_WORDS   = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state;
    state_t        next_state;
    logic [3:0]    count;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    func3_q;
    logic          read_q;
    logic          write_q;
    logic          request;
    logic          last;
    logic [AW-1:0] index;
    logic [3:0]    byte_en;
    logic [31:0]   store_lanes;
    logic [31:0]   load_data;
    logic          bad_access;
    logic          addr_unused;

    logic [31:0] mem [DEPTH_WORDS];

    assign request     = MEM_READ | MEM_WRITE;
    assign last        = (state == ACCESS) && (count == 4'd0);
    assign index       = addr_q[AW+1:2];
    assign addr_unused = ^MEM_ADDRESS[31:AW+2];

    load_store_align u_align (
        .func3       (func3_q),
        .addr_lo     (addr_q[1:0]),
        .is_store    (write_q),
        .write_data  (wdata_q),
        .read_word   (mem[index]),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data),
        .misaligned  (bad_access)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, stall and error pulse
    always_comb begin
        next_state = state;
        BUSYWAIT   = 1'b0;
        MISALIGNED = 1'b0;
        unique case (state)
            IDLE: begin
                if (request && !RESET) begin
                    BUSYWAIT   = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                BUSYWAIT = 1'b1;
                if (count == 4'd0) next_state = DONE;
            end
            DONE: begin
                MISALIGNED = bad_access;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture and latency countdown
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            func3_q <= 3'b000;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else if (state == IDLE && request) begin
            count   <= 4'(ACCESS_CYCLES - 1);
            addr_q  <= MEM_ADDRESS[AW+1:0];
            wdata_q <= MEM_WRITE_DATA;
            func3_q <= FUNC3;
            read_q  <= MEM_READ;
            write_q <= MEM_WRITE;
        end else if (state == ACCESS && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Load result; a combined read+write is a store only
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            READ_DATA <= 32'h0;
        else if (last && read_q && !write_q)
            READ_DATA <= load_data;
    end

    // Store commit; the array is deliberately not reset
    always_ff @(posedge CLK) begin
        if (last && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[index][8*b +: 8] <= store_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomised bench for data_memory with a byte-array reference
// model, per-cycle output comparison and directed scenarios.
module tb_data_memory;

    localparam int AC = 4;
    localparam int DW = 256;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [2:0]  FUNC3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    data_memory #(.ACCESS_CYCLES(AC), .DEPTH_WORDS(DW)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .FUNC3          (FUNC3),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MISALIGNED     (MISALIGNED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          busy;
        logic [31:0] rdata;
        bit          mis;
    } exp_t;

    exp_t        expq[$];
    int          checks     = 0;
    int          failures   = 0;
    int          mis_pulses = 0;
    logic [7:0]  mem_m [DW*4];
    logic [31:0] rd_m = 32'h0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic int access_size(bit st, logic [2:0] f3);
        if (st)
            return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 :
                   (f3 == 3'd2) ? 4 : 0;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 :
               (f3 == 3'd1 || f3 == 3'd5) ? 2 :
               (f3 == 3'd2) ? 4 : 0;
    endfunction

    function automatic bit model_mis(bit st, logic [2:0] f3,
                                     logic [31:0] a);
        int sz = access_size(st, f3);
        if (sz == 0) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3,
                                               logic [31:0] a);
        int base = int'(a & 32'(DW*4 - 1));
        logic [7:0]  b0 = mem_m[base];
        logic [15:0] h;
        case (f3)
            3'd0: return {{24{b0[7]}}, b0};
            3'd4: return {24'h0, b0};
            3'd1: begin
                h = {mem_m[base+1], b0};
                return {{16{h[15]}}, h};
            end
            3'd5: return {16'h0, mem_m[base+1], b0};
            default: return {mem_m[base+3], mem_m[base+2],
                             mem_m[base+1], b0};
        endcase
    endfunction

    task automatic model_store(logic [2:0] f3, logic [31:0] a,
                               logic [31:0] d);
        int base = int'(a & 32'(DW*4 - 1));
        int sz   = access_size(1'b1, f3);
        for (int i = 0; i < sz; i++) mem_m[base+i] = d[8*i +: 8];
    endtask

    // Compare the DUT against the model every cycle
    always @(negedge CLK) begin
        exp_t e;
        if (MISALIGNED === 1'b1) mis_pulses++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("busywait", {31'h0, BUSYWAIT}, {31'h0, e.busy});
            check("read_data", READ_DATA, e.rdata);
            check("misaligned", {31'h0, MISALIGNED}, {31'h0, e.mis});
        end
    end

    task automatic idle_cycle();
        @(posedge CLK); #2;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        expq.push_back('{1'b0, rd_m, 1'b0});
    endtask

    task automatic run_req(input bit rd, input bit wr,
                           input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [2:0] f3, input int rst_at);
        bit ld  = rd && !wr;
        bit mis = model_mis(wr, f3, addr);
        for (int c = 0; c <= AC + 1; c++) begin
            @(posedge CLK); #2;
            if (c == 0) begin
                MEM_READ       = rd;
                MEM_WRITE      = wr;
                MEM_ADDRESS    = addr;
                MEM_WRITE_DATA = data;
                FUNC3          = f3;
            end else begin
                MEM_READ       = 1'($urandom);
                MEM_WRITE      = 1'($urandom);
                MEM_ADDRESS    = $urandom;
                MEM_WRITE_DATA = $urandom;
                FUNC3          = 3'($urandom);
            end
            if (c == rst_at) begin
                RESET = 1'b1;
                #1;
                check("reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
                check("reset_read_data", READ_DATA, 32'h0);
                rd_m = 32'h0;
                expq.push_back('{1'b0, 32'h0, 1'b0});
                @(posedge CLK); #2;
                RESET     = 1'b0;
                MEM_READ  = 1'b0;
                MEM_WRITE = 1'b0;
                expq.push_back('{1'b0, 32'h0, 1'b0});
                return;
            end
            if (c == AC + 1) begin
                if (wr && !mis) model_store(f3, addr, data);
                if (ld) rd_m = mis ? 32'h0 : model_load(f3, addr);
                expq.push_back('{1'b0, rd_m, mis});
            end else begin
                expq.push_back('{1'b1, rd_m, 1'b0});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic [31:0] a;
        logic [2:0]  f;
        int          r;
        RESET = 1'b1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        MEM_ADDRESS = 32'h0; MEM_WRITE_DATA = 32'h0; FUNC3 = 3'b010;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", {31'h0, BUSYWAIT}, 32'h0);
        check("reset_rdata", READ_DATA, 32'h0);
        check("reset_mis", {31'h0, MISALIGNED}, 32'h0);
        @(posedge CLK); #2;
        RESET = 1'b0;
        expq.push_back('{1'b0, 32'h0, 1'b0});

        for (int i = 0; i < DW; i++)
            run_req(1'b0, 1'b1, 32'(i*4), $urandom, 3'b010, -1);
        idle_cycle();

        run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, -1);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, -1);
        check("sw_lw_0x10", READ_DATA, 32'hDEADBEEF);

        run_req(1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, -1);
        run_req(1'b0, 1'b1, 32'h23, 32'h00000080, 3'b000, -1);
        run_req(1'b1, 1'b0, 32'h23, 32'h0, 3'b000, -1);
        check("lb_0x23", READ_DATA, 32'hFFFFFF80);
        run_req(1'b1, 1'b0, 32'h23, 32'h0, 3'b100, -1);
        check("lbu_0x23", READ_DATA, 32'h00000080);
        run_req(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, -1);
        check("lh_0x22", READ_DATA, 32'hFFFF8022);
        idle_cycle();

        p0 = mis_pulses;
        run_req(1'b1, 1'b0, 32'h11, 32'h0, 3'b010, -1);
        check("lw_misaligned", READ_DATA, 32'h0);
        run_req(1'b0, 1'b1, 32'h13, 32'h0000FFFF, 3'b001, -1);
        idle_cycle();
        check("mis_pulse_count", 32'(mis_pulses - p0), 32'd2);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, -1);
        check("word_0x10_kept", READ_DATA, 32'hDEADBEEF);

        run_req(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 3'b010, -1);
        run_req(1'b0, 1'b1, 32'h40, 32'h12345678, 3'b010, AC - 1);
        run_req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, -1);
        check("reset_store_dropped", READ_DATA, 32'h0BADF00D);

        run_req(1'b0, 1'b1, 32'h000, 32'hCAFEBABE, 3'b010, -1);
        run_req(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, -1);
        check("wrap_0x400", READ_DATA, 32'hCAFEBABE);

        run_req(1'b0, 1'b1, 32'h0C, 32'h11111111, 3'b010, -1);
        run_req(1'b1, 1'b0, 32'h0C, 32'h0, 3'b010, -1);
        run_req(1'b1, 1'b1, 32'h08, 32'h0000AAAA, 3'b010, -1);
        check("rw_keeps_rdata", READ_DATA, 32'h11111111);
        run_req(1'b1, 1'b0, 32'h08, 32'h0, 3'b010, -1);
        check("rw_stored", READ_DATA, 32'h0000AAAA);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            f = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            r = $urandom_range(0, 3);
            run_req(r != 1, r == 1 || r == 2, a, $urandom, f,
                    ($urandom_range(0, 39) == 0) ?
                        $urandom_range(0, AC) : -1);
        end

        repeat (3) idle_cycle();
        @(negedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
